// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester side, the transmitter side and the baud control of
// the UART transmit arbiter.
//
// Handshake semantics (requester side): a requester raises req[i] with its
// byte on req_data[8i+7:8i] and holds both stable until ack[i] pulses for
// one cycle. In the cycle after ack it either drops req[i] or presents its
// next byte. Dropping req[i] before ack withdraws the byte. Transmitter
// side: tx_start is a one-cycle pulse with tx_data valid, and tx_done is a
// one-cycle pulse when the frame, including its stop bit, has gone out.
//
// Signals:
//   req       requester -> arbiter  per-requester byte pending (level)
//   req_data  requester -> arbiter  byte i on bits [8i+7:8i]
//   ack       arbiter -> requester  one-cycle accept pulse, one-hot
//   cfg_baud  control -> arbiter    requested baud code
//   Baud_set  arbiter -> tx         baud code applied to the transmitter
//   tx_start  arbiter -> tx         one-cycle start pulse
//   tx_data   arbiter -> tx         byte being sent
//   tx_done   tx -> arbiter         one-cycle frame complete pulse
//   busy      arbiter -> observer   high while not IDLE
//   tx_err    arbiter -> observer   one-cycle watchdog expiry pulse
//   dbg_state arbiter -> observer   current FSM state encoding
// Modports: slave = arbiter side, master = environment side.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic [2:0]        cfg_baud;
  logic [2:0]        Baud_set;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_done;
  logic              busy;
  logic              tx_err;
  logic [1:0]        dbg_state;

  modport slave (
    input  req, req_data, cfg_baud, tx_done,
    output ack, Baud_set, tx_start, tx_data, busy, tx_err, dbg_state
  );

  modport master (
    output req, req_data, cfg_baud, tx_done,
    input  ack, Baud_set, tx_start, tx_data, busy, tx_err, dbg_state
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin scheduler sharing one UART byte transmitter between NREQ byte
// sources. A grant latches the winner's byte, pulses ack, then issues a
// single-cycle tx_start. The arbiter then waits for tx_done under a
// watchdog and inserts a GAP_CYC idle gap. The baud code is only updated
// in IDLE, so a frame never sees a baud change.
//
// Ports:
//   sysclk  system clock, rising edge
//   rst     asynchronous active-low reset
//   bus     uart_tx_arbiter_if.slave (requesters, transmitter, baud, status)
// All bus outputs are registered.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 131072,
  parameter int GAP_CYC = 16
) (
  input  logic             sysclk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [2:0]      baud_q, baud_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            busy_q, busy_d;
  logic            tx_err_q, tx_err_d;

  // Round-robin search: the candidate at distance off from ptr is checked in
  // order off = 1..NREQ, so the last winner (off = NREQ) ranks lowest.
  logic            found;
  logic [PW-1:0]   win;
  logic [NREQ-1:0] win_oh;
  logic [7:0]      win_data;

  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_oh   = '0;
    win_data = '0;
    for (int off = 1; off <= NREQ; off++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && bus.req[i] &&
            ((int'(ptr_q) + off == i) || (int'(ptr_q) + off == i + NREQ))) begin
          found     = 1'b1;
          win       = PW'(i);
          win_oh[i] = 1'b1;
          win_data  = bus.req_data[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wdog_d     = wdog_q;
    gap_d      = gap_q;
    ack_d      = '0;
    baud_d     = baud_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    tx_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Baud tracks cfg_baud only while idle, including the grant cycle.
        baud_d = bus.cfg_baud;
        if (found) begin
          tx_data_d = win_data;
          ack_d     = win_oh;
          ptr_d     = win;
          state_d   = S_START;
        end
      end
      S_START: begin
        tx_start_d = 1'b1;
        wdog_d     = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        // tx_done takes precedence over a coincident watchdog expiry.
        if (bus.tx_done) begin
          gap_d   = '0;
          state_d = (GAP_CYC == 0) ? S_IDLE : S_GAP;
        end else if (wdog_q == WDOG_LAST) begin
          tx_err_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Registered busy mirrors the state that the flops are about to take.
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= PW'(NREQ - 1);
      wdog_q     <= '0;
      gap_q      <= '0;
      ack_q      <= '0;
      baud_q     <= 3'd2;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wdog_q     <= wdog_d;
      gap_q      <= gap_d;
      ack_q      <= ack_d;
      baud_q     <= baud_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      tx_err_q   <= tx_err_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.Baud_set  = baud_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.busy      = busy_q;
  assign bus.tx_err    = tx_err_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (NREQ=3, short watchdog, GAP_CYC=16).
// Stimulus pushes expected acks, bytes, baud codes and errors into queues;
// a negedge monitor pops and compares whenever the DUT pulses ack, tx_start
// or tx_err. A small transmitter model answers tx_start with tx_done.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
  localparam int NREQ    = 3;
  localparam int TIMEOUT = 1000;
  localparam int GAP_CYC = 16;
  localparam int LIM     = 3000;

  // ---------------- clock / reset ----------------
  logic sysclk = 1'b0;
  logic rst    = 1'b1;
  always #5 sysclk = ~sysclk;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(
    .NREQ(NREQ), .TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)
  ) dut (
    .sysclk(sysclk),
    .rst   (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_ack   = 0;

  logic [1:0] exp_ack_q[$];
  logic [7:0] exp_byte_q[$];
  logic [2:0] exp_baud_q[$];
  logic [0:0] exp_err_q[$];

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no response within %0d cycles", name, LIM);
  endtask

  // ---------------- transmitter model ----------------
  logic model_en   = 1'b1;
  int   model_dly  = 20;
  int   model_cnt  = 0;
  logic model_done = 1'b0;
  logic man_done   = 1'b0;
  assign bus.tx_done = model_done | man_done;

  always @(posedge sysclk) begin
    #1;
    model_done = 1'b0;
    if (!rst) model_cnt = 0;
    else if (model_cnt != 0) begin
      model_cnt--;
      if (model_cnt == 0) model_done = 1'b1;
    end else if (bus.tx_start && model_en) model_cnt = model_dly;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge sysclk) begin
    if (rst) begin
      if (bus.ack != 0) begin
        n_ack++;
        check("ack_onehot", $countones(bus.ack), 1);
        check("ack_with_start", {31'd0, bus.tx_start}, 0);
        if (exp_ack_q.size() == 0) check("ack_unexpected", {29'd0, bus.ack}, 0);
        else begin
          logic [1:0] idx;
          idx = exp_ack_q.pop_front();
          check("ack_idx", {29'd0, bus.ack}, 32'd1 << idx);
        end
      end
      if (bus.tx_start) begin
        if (exp_byte_q.size() == 0) check("start_unexpected", {31'd0, bus.tx_start}, 0);
        else begin
          check("tx_data", {24'd0, bus.tx_data}, {24'd0, exp_byte_q.pop_front()});
          if (exp_baud_q.size() != 0)
            check("baud_at_start", {29'd0, bus.Baud_set}, {29'd0, exp_baud_q.pop_front()});
        end
      end
      if (bus.tx_err) begin
        if (exp_err_q.size() == 0) check("err_unexpected", {31'd0, bus.tx_err}, 0);
        else void'(exp_err_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return bus.tx_start;
      1:       return bus.tx_done;
      2:       return bus.tx_err;
      default: return !bus.busy;
    endcase
  endfunction

  // Returns at the negedge where the selected condition is seen.
  task automatic wait_for(input int w, input int lim, input string name);
    int k = 0;
    @(negedge sysclk);
    while (!sig(w) && k < lim) begin
      @(negedge sysclk);
      k++;
    end
    if (!sig(w)) timeout_fail(name);
  endtask

  // Waits for an ack and drops the acked request in the following cycle.
  task automatic wait_ack_drop(input string name);
    int k = 0;
    logic [NREQ-1:0] a;
    @(negedge sysclk);
    while (bus.ack == 0 && k < LIM) begin
      @(negedge sysclk);
      k++;
    end
    if (bus.ack == 0) timeout_fail(name);
    a = bus.ack;
    @(posedge sysclk);
    #1;
    bus.req = bus.req & ~a;
  endtask

  task automatic expect_tx(input logic [1:0] idx, input logic [7:0] b, input logic [2:0] baud);
    exp_ack_q.push_back(idx);
    exp_byte_q.push_back(b);
    exp_baud_q.push_back(baud);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, {29'd0, bus.ack}, 0);
    check({tag, "_tx_start"}, {31'd0, bus.tx_start}, 0);
    check({tag, "_tx_data"}, {24'd0, bus.tx_data}, 0);
    check({tag, "_tx_err"}, {31'd0, bus.tx_err}, 0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 0);
    check({tag, "_baud"}, {29'd0, bus.Baud_set}, 2);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n, t0, t1, base;
    bus.req      = '0;
    bus.req_data = '0;
    bus.cfg_baud = 3'd2;
    #2 rst = 1'b0;
    tick(3);
    @(negedge sysclk);
    check_reset_outputs("reset");
    check("reset_state", {30'd0, bus.dbg_state}, 0);
    tick(1);
    rst = 1'b1;
    tick(2);

    // Single byte from requester 1.
    bus.req_data = {8'h00, 8'hA5, 8'h00};
    bus.req      = 3'b010;
    expect_tx(2'd1, 8'hA5, 3'd2);
    @(negedge sysclk);
    check("single_no_early_ack", {29'd0, bus.ack}, 0);
    @(negedge sysclk);
    check("single_ack", {29'd0, bus.ack}, 3'b010);
    check("single_start_late", {31'd0, bus.tx_start}, 0);
    tick(1);
    bus.req = '0;
    @(negedge sysclk);
    check("single_start", {31'd0, bus.tx_start}, 1);
    check("single_data", {24'd0, bus.tx_data}, 8'hA5);
    check("single_busy", {31'd0, bus.busy}, 1);
    wait_for(1, LIM, "single_done");
    n = 0;
    @(negedge sysclk);
    while (bus.busy && n < 100) begin
      n++;
      @(negedge sysclk);
    end
    check("single_gap_len", n, GAP_CYC);
    check("single_data_hold", {24'd0, bus.tx_data}, 8'hA5);

    // Reset so the pointer restarts with requester 0 first.
    tick(1);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);

    // Contention: all three held, expect 0,1,2,0.
    model_dly    = 200;
    bus.req_data = {8'h33, 8'h22, 8'h11};
    bus.req      = 3'b111;
    expect_tx(2'd0, 8'h11, 3'd2);
    expect_tx(2'd1, 8'h22, 3'd2);
    expect_tx(2'd2, 8'h33, 3'd2);
    expect_tx(2'd0, 8'h11, 3'd2);
    base = n_ack;
    n = 0;
    while (n_ack < base + 4 && n < LIM) begin
      @(negedge sysclk);
      n++;
    end
    if (n_ack < base + 4) timeout_fail("contention_acks");
    tick(1);
    bus.req = '0;
    wait_for(3, LIM, "contention_idle");

    // Rotation: grant 2, then 3'b101 must go 0 then 2.
    tick(1);
    bus.req_data = {8'h44, 8'h00, 8'h00};
    bus.req      = 3'b100;
    expect_tx(2'd2, 8'h44, 3'd2);
    wait_ack_drop("rot_first");
    wait_for(3, LIM, "rot_idle1");
    tick(1);
    bus.req_data = {8'h66, 8'h00, 8'h55};
    bus.req      = 3'b101;
    expect_tx(2'd0, 8'h55, 3'd2);
    expect_tx(2'd2, 8'h66, 3'd2);
    wait_ack_drop("rot_second");
    wait_ack_drop("rot_third");
    wait_for(3, LIM, "rot_idle2");

    // Watchdog: the transmitter never answers.
    model_en = 1'b0;
    tick(1);
    bus.req_data = {8'h00, 8'h00, 8'h77};
    bus.req      = 3'b001;
    expect_tx(2'd0, 8'h77, 3'd2);
    exp_err_q.push_back(1'b1);
    wait_ack_drop("wdog_ack");
    wait_for(0, LIM, "wdog_start");
    t0 = cyc;
    wait_for(2, TIMEOUT + 100, "wdog_err");
    t1 = cyc;
    check("wdog_latency", t1 - t0, TIMEOUT);
    @(negedge sysclk);
    check("wdog_err_pulse", {31'd0, bus.tx_err}, 0);
    check("wdog_busy_after", {31'd0, bus.busy}, 0);
    tick(1);
    man_done = 1'b1;
    tick(1);
    man_done = 1'b0;
    tick(3);
    @(negedge sysclk);
    check("late_done_ignored", {31'd0, bus.busy}, 0);
    model_en = 1'b1;

    // Baud lock: change cfg_baud mid-frame.
    tick(1);
    bus.req_data = {8'h00, 8'h88, 8'h00};
    bus.req      = 3'b010;
    expect_tx(2'd1, 8'h88, 3'd2);
    wait_ack_drop("baud_ack");
    wait_for(0, LIM, "baud_start");
    tick(5);
    bus.cfg_baud = 3'd0;
    repeat (10) @(negedge sysclk);
    check("baud_frozen_wait", {29'd0, bus.Baud_set}, 2);
    wait_for(1, LIM, "baud_done");
    @(negedge sysclk);
    check("baud_frozen_gap", {29'd0, bus.Baud_set}, 2);
    check("baud_gap_busy", {31'd0, bus.busy}, 1);
    tick(1);
    bus.req_data = {8'h00, 8'h00, 8'h99};
    bus.req      = 3'b001;
    expect_tx(2'd0, 8'h99, 3'd0);
    wait_ack_drop("baud_ack2");
    check("baud_applied", {29'd0, bus.Baud_set}, 0);
    wait_for(3, LIM, "baud_idle");

    // Reset while waiting for tx_done with requests pending.
    tick(1);
    bus.req_data = {8'hAA, 8'h00, 8'h00};
    bus.req      = 3'b100;
    expect_tx(2'd2, 8'hAA, 3'd0);
    wait_ack_drop("rstw_ack");
    wait_for(0, LIM, "rstw_start");
    tick(10);
    check("rstw_in_wait", {30'd0, bus.dbg_state}, 2);
    bus.req_data = {8'hAA, 8'hB1, 8'hB0};
    bus.req      = 3'b011;
    rst = 1'b0;
    @(negedge sysclk);
    check_reset_outputs("rstw");
    tick(1);
    rst = 1'b1;
    expect_tx(2'd0, 8'hB0, 3'd0);
    expect_tx(2'd1, 8'hB1, 3'd0);
    wait_ack_drop("rstw_regrant0");
    wait_ack_drop("rstw_regrant1");
    wait_for(3, LIM, "rstw_idle");
    tick(2);

    check("left_acks", exp_ack_q.size(), 0);
    check("left_bytes", exp_byte_q.size(), 0);
    check("left_errs", exp_err_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART byte transmitter between NREQ independent byte sources. It accepts one byte at a time from a requester and drives a single-cycle start pulse with the data to the transmitter. It then waits for the transmitter's done pulse, guarded by a watchdog, before inserting an inter-byte gap. It also owns the transmitter's 3-bit baud selection, and applies a baud change only when the link is idle.

Parameters:
NREQ, 3, number of requesters (2..8)
TIMEOUT, 131072, max sysclk cycles to wait for tx_done after tx_start (> one 4800-baud frame at 50 MHz = 104160)
GAP_CYC, 16, idle sysclk cycles inserted after each tx_done (0 = no gap)

Ports:
sysclk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-low reset
req  in  NREQ  per-requester level request; bit i high = byte pending
req_data  in  8*NREQ  byte of requester i on bits [8i+7:8i]
ack  out  NREQ  one-cycle pulse, bit i = requester i's byte accepted
cfg_baud  in  3  requested baud code (0=4800, 1=9600, 2=115200, others=115200)
Baud_set  out  3  baud code driven to transmitter
tx_start  out  1  one-cycle start pulse to transmitter
tx_data  out  8  byte to transmitter, stable from tx_start until next grant
tx_done  in  1  one-cycle pulse from transmitter, frame (incl. stop bit) complete
busy  out  1  high whenever state != IDLE
tx_err  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (async, rst=0): state IDLE; ack=0, tx_start=0, tx_data=0, tx_err=0, busy=0; Baud_set=2; rr pointer=NREQ-1 (requester 0 has highest priority first); counters 0.
- All outputs registered.
- States: IDLE, START, WAIT, GAP.
- IDLE:
  - Baud_set<=cfg_baud every cycle.
  - If req!=0: select the first set bit searching from (ptr+1) mod NREQ upward with wrap. For winner i: tx_data<=req_data[i], ack[i]<=1, ptr<=i, go to START.
  - Latency: req sampled at edge k; ack/tx_data valid after edge k, tx_start after edge k+1.
- START: tx_start=1 for exactly this cycle; clear wdog counter; go to WAIT.
- WAIT:
  - wdog increments each cycle.
  - tx_done=1 -> go to GAP (to IDLE directly if GAP_CYC=0).
  - Else if wdog==TIMEOUT-1 -> tx_err pulse, go to IDLE.
  - If tx_done and expiry coincide, tx_done wins and there is no tx_err.
- GAP: count GAP_CYC cycles, then go to IDLE. A new grant is possible on the cycle after entering IDLE.
- tx_done outside WAIT is ignored.
- Baud_set is frozen in START/WAIT/GAP. A cfg_baud change while busy takes effect on the first IDLE cycle, before or with the next grant. The transmitter therefore never sees a baud change mid-frame.
- Requester protocol:
  - Hold req and req_data stable until ack.
  - Drop req, or present the next byte, in the cycle after ack.
  - Dropping req before ack is permitted; the byte is then not sent.
  - The arbiter samples req_data only in the IDLE grant cycle.
- Fairness: after granting i, requester i has lowest priority next round. With all req held, the grant order is 0,1,..,NREQ-1,0,...
- At most one ack bit is high at any time. ack and tx_start are never high in the same cycle.
- Reset mid-operation returns to the reset state immediately. No pending ack or tx_start is reissued.

Test Plan:
- Single byte: req=3'b010, req_data[15:8]=8'hA5 -> ack=3'b010 for 1 cycle; tx_start 1 cycle later with tx_data=8'hA5; busy=1 until GAP_CYC cycles after tx_done.
- Contention: req=3'b111 held with distinct bytes 11/22/33, transmitter model returns tx_done 200 cycles after each start -> tx order 11,22,33,11; no double ack.
- Rotation: after granting 2, req=3'b101 -> requester 0 granted, then requester 2.
- Watchdog: start issued, tx_done never arrives -> tx_err pulse exactly TIMEOUT cycles after tx_start; busy=0 on the next cycle; tx_done arriving later is ignored.
- Baud lock: cfg_baud changes 2->0 during WAIT -> Baud_set stays 2 until IDLE, then 0 before the next tx_start.
- Reset in WAIT: rst=0 for 1 cycle -> all outputs at reset values, Baud_set=2; a pending req is granted afresh starting from requester 0.
